dqs_rdvalid_ctrl: RTL and testbench

DQS_RDVALID_CTRL -- requirements
Module: dqs_rdvalid_ctrl

---
 rtl/dqsrv_pkg.sv | 21 ++
 rtl/dqsrv_lane.sv | 125 ++++++++++++
 rtl/dqs_rdvalid_ctrl.sv | 153 +++++++++++++++
 tb/tb_dqs_rdvalid_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dqsrv_pkg.sv
// dqsrv_pkg: lane-state encoding and timing constants shared by dqs_rdvalid_ctrl
// and its per-lane controller dqsrv_lane.
package dqsrv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } lane_state_e;

  // Cycles a lane waits for a DQS preamble, counting the window-open cycle itself.
  localparam int unsigned TIMEOUT = 2;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    CAL_OFF   = 2'd0,
    CAL_ARMED = 2'd1,
    CAL_MEAS  = 2'd2
  } cal_state_e;

endpackage

// File: rtl/dqsrv_lane.sv
// dqsrv_lane: one DQS byte lane -- IDLE/WAIT/BURST tracker with burst down-counter,
// one-deep window queue, timeout and registered DATAVALID/PRMBDET/LATERR.
module dqsrv_lane
  import dqsrv_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter bit          NRZ_EN    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic win,
  input  logic prmb,
  output logic dv,
  output logic det,
  output logic laterr,
  output logic idle
);

  localparam int unsigned      CNT_W    = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             queue_q, queue_d;
  logic             dv_q, dv_d;
  logic             det_q, det_d;
  logic             laterr_q, laterr_d;
  logic             enter;

  // The window-open cycle already counts as the first waiting cycle, so a preamble
  // seen in that cycle starts the burst without a WAIT cycle in between.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    queue_d  = queue_q;
    laterr_d = 1'b0;
    enter    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win) begin
          if (prmb) begin
            enter = 1'b1;
          end else begin
            state_d = WAIT;
            tmo_d   = TMO_LOAD;
          end
        end
      end
      WAIT: begin
        if (prmb) begin
          enter = 1'b1;
        end else if (win) begin
          tmo_d = TMO_LOAD;
        end else if (tmo_q <= TMO_W'(1)) begin
          state_d  = IDLE;
          laterr_d = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      BURST: begin
        if (cnt_q == '0) begin
          queue_d = 1'b0;
          if (win || queue_q) begin
            if (prmb) begin
              enter = 1'b1;
            end else begin
              state_d = WAIT;
              tmo_d   = TMO_LOAD;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (win) begin
            if (queue_q) begin
              laterr_d = 1'b1;
            end else begin
              queue_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter) begin
      state_d = BURST;
      cnt_d   = CNT_LOAD;
    end

    det_d = (state_d == BURST);
    dv_d  = NRZ_EN ? (dv_q ^ enter) : det_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      queue_q  <= 1'b0;
      dv_q     <= 1'b0;
      det_q    <= 1'b0;
      laterr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      queue_q  <= queue_d;
      dv_q     <= dv_d;
      det_q    <= det_d;
      laterr_q <= laterr_d;
    end
  end

  assign dv     = dv_q;
  assign det    = det_q;
  assign laterr = laterr_q;
  assign idle   = (state_q == IDLE);

endmodule

// File: rtl/dqs_rdvalid_ctrl.sv
// dqs_rdvalid_ctrl: READ-latency shift register feeding LANES dqsrv_lane trackers.
// Optional read-latency calibration is built only when DQSRV_LATCAL_EN is defined.
module dqs_rdvalid_ctrl
  import dqsrv_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MAX_LAT   = 7,
  parameter string       NRZMODE   = "DISABLED"
) (
  input  logic                         SCLK,
  input  logic                         RSTN,
  input  logic                         READ,
  input  logic [$clog2(MAX_LAT+1)-1:0] RDLAT,
  input  logic [LANES-1:0]             PRMB,
`ifdef DQSRV_LATCAL_EN
  input  logic                         CALSTART,
  output logic [$clog2(MAX_LAT+1)-1:0] CALLAT,
  output logic                         CALDONE,
  output logic                         CALERR,
`endif
  output logic [LANES-1:0]             DATAVALID,
  output logic [LANES-1:0]             PRMBDET,
  output logic [LANES-1:0]             LATERR
);

  localparam int unsigned      LAT_W   = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_CAP = LAT_W'(MAX_LAT);
  localparam bit               NRZ_EN  = (NRZMODE == "ENABLED");

  logic [MAX_LAT:0]   sr_q, sr_d;
  logic [LAT_W-1:0]   rdlat_q, rdlat_d;
  logic [LAT_W-1:0]   rdlat_clamped;
  logic [LANES-1:0]   lane_idle;
  logic               win;

  // sr_q[0] holds the READ of the previous cycle, so tap k opens the window k+1
  // cycles after READ. Latency is frozen while any READ or lane is still active.
  always_comb begin
    sr_d          = {sr_q[MAX_LAT-1:0], READ};
    rdlat_clamped = (int'(RDLAT) > int'(MAX_LAT)) ? LAT_CAP : RDLAT;
    rdlat_d       = rdlat_q;
    if (!(|sr_q) && (&lane_idle)) begin
      rdlat_d = rdlat_clamped;
    end
    win = sr_q[rdlat_q];
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      sr_q    <= '0;
      rdlat_q <= LAT_CAP;
    end else begin
      sr_q    <= sr_d;
      rdlat_q <= rdlat_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dqsrv_lane #(
      .BURST_LEN (BURST_LEN),
      .NRZ_EN    (NRZ_EN)
    ) u_lane (
      .clk    (SCLK),
      .rst_n  (RSTN),
      .win    (win),
      .prmb   (PRMB[g]),
      .dv     (DATAVALID[g]),
      .det    (PRMBDET[g]),
      .laterr (LATERR[g]),
      .idle   (lane_idle[g])
    );
  end

`ifdef DQSRV_LATCAL_EN
  localparam int unsigned      CAL_W     = $clog2(MAX_LAT + 4);
  localparam logic [CAL_W-1:0] CAL_LIMIT = CAL_W'(MAX_LAT + 2);

  cal_state_e       cal_st_q, cal_st_d;
  logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
  logic [CAL_W-1:0] cal_max_q, cal_max_d;
  logic [LANES-1:0] cal_seen_q, cal_seen_d;
  logic [LAT_W-1:0] callat_q, callat_d;
  logic             caldone_q, caldone_d;
  logic             calerr_q, calerr_d;

  // Counter is 1 in the cycle after READ; first PRMB per lane is monotonic in time,
  // so the latest newly reporting lane always carries the maximum.
  always_comb begin
    cal_st_d   = cal_st_q;
    cal_cnt_d  = cal_cnt_q;
    cal_max_d  = cal_max_q;
    cal_seen_d = cal_seen_q;
    callat_d   = callat_q;
    caldone_d  = 1'b0;
    calerr_d   = 1'b0;
    case (cal_st_q)
      CAL_OFF: begin
        if (CALSTART) cal_st_d = CAL_ARMED;
      end
      CAL_ARMED: begin
        if (READ) begin
          cal_st_d   = CAL_MEAS;
          cal_cnt_d  = CAL_W'(1);
          cal_max_d  = '0;
          cal_seen_d = '0;
        end
      end
      CAL_MEAS: begin
        cal_seen_d = cal_seen_q | PRMB;
        if (|(PRMB & ~cal_seen_q)) cal_max_d = cal_cnt_q;
        if (&cal_seen_d) begin
          cal_st_d  = CAL_OFF;
          caldone_d = 1'b1;
          callat_d  = (int'(cal_max_d) - 1 > int'(MAX_LAT)) ? LAT_CAP
                                                            : LAT_W'(cal_max_d - CAL_W'(1));
        end else if (cal_cnt_q >= CAL_LIMIT) begin
          cal_st_d = CAL_OFF;
          calerr_d = 1'b1;
        end else begin
          cal_cnt_d = cal_cnt_q + CAL_W'(1);
        end
      end
      default: cal_st_d = CAL_OFF;
    endcase
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      cal_st_q   <= CAL_OFF;
      cal_cnt_q  <= '0;
      cal_max_q  <= '0;
      cal_seen_q <= '0;
      callat_q   <= '0;
      caldone_q  <= 1'b0;
      calerr_q   <= 1'b0;
    end else begin
      cal_st_q   <= cal_st_d;
      cal_cnt_q  <= cal_cnt_d;
      cal_max_q  <= cal_max_d;
      cal_seen_q <= cal_seen_d;
      callat_q   <= callat_d;
      caldone_q  <= caldone_d;
      calerr_q   <= calerr_d;
    end
  end

  assign CALLAT  = callat_q;
  assign CALDONE = caldone_q;
  assign CALERR  = calerr_q;
`endif

endmodule

// File: tb/tb_dqs_rdvalid_ctrl.sv
// tb_dqs_rdvalid_ctrl: directed and random READ/PRMB stimulus on a level-mode and a
// toggle-mode instance, compared every cycle against an event-time reference model.
module tb_dqs_rdvalid_ctrl;

  localparam int LANES = 2;
  localparam int BL    = 4;
  localparam int ML    = 6;
  localparam int LW    = 3;
  localparam int TMO   = 2;

  logic             SCLK = 1'b0;
  logic             RSTN;
  logic             READ;
  logic [LW-1:0]    RDLAT;
  logic [LANES-1:0] PRMB;
  logic [LANES-1:0] dv_rz, det_rz, le_rz;
  logic [LANES-1:0] dv_nrz, det_nrz, le_nrz;

  int checks = 0;
  int errors = 0;

  always #5 SCLK = ~SCLK;

  dqs_rdvalid_ctrl #(
    .LANES(LANES), .BURST_LEN(BL), .MAX_LAT(ML), .NRZMODE("DISABLED")
  ) u_dut_rz (
    .SCLK(SCLK), .RSTN(RSTN), .READ(READ), .RDLAT(RDLAT), .PRMB(PRMB),
    .DATAVALID(dv_rz), .PRMBDET(det_rz), .LATERR(le_rz)
  );

  dqs_rdvalid_ctrl #(
    .LANES(LANES), .BURST_LEN(BL), .MAX_LAT(ML), .NRZMODE("ENABLED")
  ) u_dut_nrz (
    .SCLK(SCLK), .RSTN(RSTN), .READ(READ), .RDLAT(RDLAT), .PRMB(PRMB),
    .DATAVALID(dv_nrz), .PRMBDET(det_nrz), .LATERR(le_nrz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: lanes tracked by absolute cycle numbers (deadline, last burst cycle).
  int mode [LANES];        // 0 idle, 1 waiting, 2 bursting
  int deadline [LANES];
  int burst_last [LANES];
  bit queued [LANES];
  bit tog [LANES];
  int reads[$];
  int windows[$];
  int lat;
  int cyc;
  logic [LANES-1:0] exp_dv_rz, exp_dv_nrz, exp_det, exp_le;

  int cur_run, max_run, le_cnt;
  logic [LW-1:0]    cur_lat;
  logic             rnd_rd;
  logic [LANES-1:0] rnd_pm;

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      mode[l] = 0; deadline[l] = 0; burst_last[l] = 0; queued[l] = 0; tog[l] = 0;
    end
    reads.delete();
    windows.delete();
    exp_dv_rz = '0; exp_dv_nrz = '0; exp_det = '0; exp_le = '0;
  endtask

  task automatic model_step(input bit rd, input logic [LANES-1:0] pm, input int lat_in);
    bit all_idle, busy, win, waiting;
    all_idle = 1'b1;
    for (int l = 0; l < LANES; l++) if (mode[l] != 0) all_idle = 1'b0;
    busy = 1'b0;
    foreach (reads[i]) if (cyc >= reads[i] + 1 && cyc <= reads[i] + 1 + ML) busy = 1'b1;
    if (!busy && all_idle) lat = (lat_in > ML) ? ML : lat_in;
    win = 1'b0;
    foreach (windows[i]) if (windows[i] == cyc) win = 1'b1;
    if (rd) begin
      reads.push_back(cyc);
      windows.push_back(cyc + 1 + lat);
    end
    while (reads.size() > 0 && reads[0] + 1 + ML < cyc) void'(reads.pop_front());
    while (windows.size() > 0 && windows[0] < cyc) void'(windows.pop_front());

    for (int l = 0; l < LANES; l++) begin
      exp_le[l] = 1'b0;
      waiting   = 1'b0;
      if (mode[l] == 0 && win) begin
        waiting = 1'b1; deadline[l] = cyc + TMO - 1;
      end else if (mode[l] == 1) begin
        waiting = 1'b1;
        if (win) deadline[l] = cyc + TMO - 1;
      end else if (mode[l] == 2 && cyc == burst_last[l]) begin
        if (win || queued[l]) begin
          waiting = 1'b1; deadline[l] = cyc + TMO - 1;
        end
        queued[l] = 1'b0;
      end

      if (waiting && pm[l]) begin
        mode[l] = 2; burst_last[l] = cyc + BL; tog[l] = !tog[l];
      end else if (waiting) begin
        if (cyc >= deadline[l]) begin
          mode[l] = 0; exp_le[l] = 1'b1;
        end else begin
          mode[l] = 1;
        end
      end else if (mode[l] == 2) begin
        if (cyc == burst_last[l]) mode[l] = 0;
        else if (win) begin
          if (queued[l]) exp_le[l] = 1'b1;
          else queued[l] = 1'b1;
        end
      end
      exp_det[l]    = (mode[l] == 2);
      exp_dv_rz[l]  = (mode[l] == 2);
      exp_dv_nrz[l] = tog[l];
    end
    cyc++;
  endtask

  task automatic check_outputs(input string sfx);
    check({"DATAVALID_rz", sfx},  32'(dv_rz),   32'(exp_dv_rz));
    check({"PRMBDET_rz", sfx},    32'(det_rz),  32'(exp_det));
    check({"LATERR_rz", sfx},     32'(le_rz),   32'(exp_le));
    check({"DATAVALID_nrz", sfx}, 32'(dv_nrz),  32'(exp_dv_nrz));
    check({"PRMBDET_nrz", sfx},   32'(det_nrz), 32'(exp_det));
    check({"LATERR_nrz", sfx},    32'(le_nrz),  32'(exp_le));
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next one.
  task automatic run_cycle(input logic rd, input logic [LANES-1:0] pm, input logic [LW-1:0] lat_in);
    READ  = rd;
    PRMB  = pm;
    RDLAT = lat_in;
    model_step(rd, pm, int'(lat_in));
    @(posedge SCLK);
    #1;
    check_outputs("");
    if (dv_rz[0]) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (le_rz[0]) le_cnt++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, cur_lat);
  endtask

  task automatic apply_reset();
    RSTN = 1'b0;
    READ = 1'b0;
    PRMB = '0;
    #1;
    model_reset();
    check_outputs("_async_rst");
    @(posedge SCLK);
    #1;
    check_outputs("_in_rst");
    RSTN = 1'b1;
  endtask

  initial begin
    RSTN = 1'b0; READ = 1'b0; PRMB = '0; RDLAT = 3'd3;
    cyc = 0; lat = 0; cur_run = 0; max_run = 0; le_cnt = 0; cur_lat = 3'd3;
    model_reset();
    repeat (3) @(posedge SCLK);
    #1;
    check_outputs("_reset");
    RSTN = 1'b1;
    idle_cycles(3);

    // Single read, preamble in the window cycle: 4-cycle burst.
    cur_lat = 3'd3; max_run = 0;
    run_cycle(1'b1, '0, cur_lat);
    idle_cycles(3);
    run_cycle(1'b0, 2'b01, cur_lat);
    idle_cycles(8);
    check("single_burst_len", 32'(max_run), 32'd4);

    // Single read, no preamble: exactly one LATERR pulse.
    le_cnt = 0;
    run_cycle(1'b1, '0, cur_lat);
    idle_cycles(10);
    check("timeout_pulses", 32'(le_cnt), 32'd1);

    // Back-to-back reads 4 cycles apart: DATAVALID continuous for 8 cycles.
    max_run = 0;
    run_cycle(1'b1, '0, cur_lat);
    idle_cycles(3);
    run_cycle(1'b1, 2'b11, cur_lat);
    idle_cycles(3);
    run_cycle(1'b0, 2'b11, cur_lat);
    idle_cycles(8);
    check("b2b_run", 32'(max_run), 32'd8);

    // Out-of-range latency clamps to ML; reset asserted mid-burst.
    cur_lat = 3'd7;
    run_cycle(1'b1, '0, cur_lat);
    idle_cycles(ML);
    run_cycle(1'b0, 2'b01, cur_lat);
    check("clamped_window_burst", 32'(dv_rz[0]), 32'd1);
    idle_cycles(2);
    apply_reset();
    idle_cycles(4);

    for (int n = 0; n < 1500; n++) begin
      if (n % 60 == 0) cur_lat = LW'($urandom_range(0, 7));
      if (n == 750) apply_reset();
      rnd_rd = ($urandom_range(0, 4) == 0);
      for (int l = 0; l < LANES; l++) rnd_pm[l] = ($urandom_range(0, 2) == 0);
      run_cycle(rnd_rd, rnd_pm, cur_lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
